spi_mem_master: RTL and testbench

//  Single-byte SPI master between the CPU core and the external serial SRAM pins (23LC-style, mode 0).

---
 rtl/spi_mem_master_if.sv | 24 ++
 rtl/spi_mem_master.sv | 191 +++++++++++++++++++
 tb/tb_spi_mem_master.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_mem_master_if.sv
// spi_mem_master_if: CPU-side request/response bundle for spi_mem_master.
// The master modport is the CPU fetch/load/store side; the slave modport is the SPI engine.
interface spi_mem_master_if #(
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [7:0]        req_wdata;
    logic              resp_valid;
    logic [7:0]        resp_rdata;
    logic              busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, busy
    );
endinterface

// File: rtl/spi_mem_master.sv
// spi_mem_master: single-byte SPI mode-0 master for 23LC-style serial SRAM.
// One accepted request becomes one framed transaction: CMD, ADDR (MSB first), 8 data bits.
// Optional build macro SPI_MEM_FASTREAD_EN: reads use CMD 0x0B with 8 dummy SCK cycles
// between address and data; writes are unaffected. Without it no dummy-phase logic exists.
module spi_mem_master #(
    parameter int CLK_DIV = 2,
    parameter int ADDR_W  = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    spi_mem_master_if.slave bus,
    output logic            spi_cs_n_o,
    output logic            spi_sck_o,
    output logic            spi_mosi_o,
    input  logic            spi_miso_i
);
    localparam int NBITS_RW = 8 + ADDR_W + 8;
`ifdef SPI_MEM_FASTREAD_EN
    localparam int NBITS_RD = NBITS_RW + 8;
`else
    localparam int NBITS_RD = NBITS_RW;
`endif
    localparam int SR_W   = NBITS_RD;
    localparam int BCNT_W = $clog2(SR_W + 1);
    localparam int DIV_W  = $clog2(CLK_DIV) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t            state_q;
    logic [SR_W-1:0]   sr_q;
    logic [BCNT_W-1:0] bit_cnt_q;
    logic [DIV_W-1:0]  div_q;
    logic              we_q;
    logic [7:0]        rdata_sr_q;
    logic [7:0]        rdata_sr_d;
    logic [7:0]        rdata_q;
    logic              resp_valid_q;
    logic              busy_q;
    logic              ready_q;
    logic              cs_n_q;
    logic              sck_q;

    logic              div_end_s;
    logic              gap_end_s;
    logic              last_bit_s;
    logic              sample_s;
    logic [SR_W-1:0]   load_sr_s;
    logic [BCNT_W-1:0] load_cnt_s;

    // Phase-end decodes and the MISO capture path; only the final 8 bits of a frame are captured.
    always_comb begin
        div_end_s  = (div_q == DIV_W'(CLK_DIV - 1));
        gap_end_s  = (div_q == DIV_W'(2 * CLK_DIV - 1));
        last_bit_s = (bit_cnt_q == BCNT_W'(1));
        sample_s   = (state_q == ST_SHIFT) && sck_q && (div_q == {DIV_W{1'b0}})
                     && (bit_cnt_q <= BCNT_W'(8));
        if (sample_s) begin
            rdata_sr_d = {rdata_sr_q[6:0], spi_miso_i};
        end else begin
            rdata_sr_d = rdata_sr_q;
        end
    end

    // Frame image (MSB leaves first) and bit count for the request on the bus.
    always_comb begin
`ifdef SPI_MEM_FASTREAD_EN
        if (bus.req_we) begin
            load_sr_s  = {8'h02, bus.req_addr, bus.req_wdata, 8'h00};
            load_cnt_s = BCNT_W'(NBITS_RW);
        end else begin
            load_sr_s  = {8'h0B, bus.req_addr, 8'h00, 8'h00};
            load_cnt_s = BCNT_W'(NBITS_RD);
        end
`else
        load_cnt_s = BCNT_W'(NBITS_RW);
        if (bus.req_we) begin
            load_sr_s = {8'h02, bus.req_addr, bus.req_wdata};
        end else begin
            load_sr_s = {8'h03, bus.req_addr, 8'h00};
        end
`endif
    end

    // Transaction sequencer: accept, shift the frame, pulse the response, then hold CS high for the gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sr_q         <= {SR_W{1'b0}};
            bit_cnt_q    <= {BCNT_W{1'b0}};
            div_q        <= {DIV_W{1'b0}};
            we_q         <= 1'b0;
            rdata_sr_q   <= 8'h00;
            rdata_q      <= 8'h00;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            ready_q      <= 1'b1;
            cs_n_q       <= 1'b1;
            sck_q        <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid && ready_q) begin
                        state_q    <= ST_SHIFT;
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        cs_n_q     <= 1'b0;
                        sck_q      <= 1'b0;
                        sr_q       <= load_sr_s;
                        bit_cnt_q  <= load_cnt_s;
                        div_q      <= {DIV_W{1'b0}};
                        we_q       <= bus.req_we;
                        rdata_sr_q <= 8'h00;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    rdata_sr_q <= rdata_sr_d;
                    if (!sck_q) begin
                        if (div_end_s) begin
                            sck_q <= 1'b1;
                            div_q <= {DIV_W{1'b0}};
                        end else begin
                            div_q <= div_q + DIV_W'(1);
                        end
                    end else begin
                        if (div_end_s) begin
                            sck_q <= 1'b0;
                            div_q <= {DIV_W{1'b0}};
                            if (last_bit_s) begin
                                state_q      <= ST_DONE;
                                cs_n_q       <= 1'b1;
                                sr_q         <= {SR_W{1'b0}};
                                bit_cnt_q    <= {BCNT_W{1'b0}};
                                resp_valid_q <= 1'b1;
                                if (!we_q) begin
                                    rdata_q <= rdata_sr_d;
                                end else begin
                                    rdata_q <= rdata_q;
                                end
                            end else begin
                                sr_q      <= {sr_q[SR_W-2:0], 1'b0};
                                bit_cnt_q <= bit_cnt_q - BCNT_W'(1);
                            end
                        end else begin
                            div_q <= div_q + DIV_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    resp_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    div_q        <= {DIV_W{1'b0}};
                    state_q      <= ST_GAP;
                end
                ST_GAP: begin
                    if (gap_end_s) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                        div_q   <= {DIV_W{1'b0}};
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    ready_q      <= 1'b1;
                    busy_q       <= 1'b0;
                    resp_valid_q <= 1'b0;
                    cs_n_q       <= 1'b1;
                    sck_q        <= 1'b0;
                    sr_q         <= {SR_W{1'b0}};
                    div_q        <= {DIV_W{1'b0}};
                end
            endcase
        end
    end

    assign spi_cs_n_o     = cs_n_q;
    assign spi_sck_o      = sck_q;
    assign spi_mosi_o     = sr_q[SR_W-1];
    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_spi_mem_master.sv
// tb_spi_mem_master: scoreboard bench for spi_mem_master.
// Instance 0 runs at CLK_DIV=1, instance 1 at CLK_DIV=2. A serial SRAM model per instance
// captures MOSI, drives MISO and measures frame timing; a monitor pops expectations on resp_valid.
module tb_spi_mem_master;
    logic clk;
    logic rst_n;

    spi_mem_master_if #(.ADDR_W(16)) bus0 ();
    spi_mem_master_if #(.ADDR_W(16)) bus1 ();

    logic [1:0] cs_w, sck_w, mosi_w;
    bit   [1:0] miso_r;
    logic [1:0] rv_w, rdy_w, busy_w;
    logic [7:0] rd_w [2];

    spi_mem_master #(.CLK_DIV(1), .ADDR_W(16)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0),
        .spi_cs_n_o(cs_w[0]), .spi_sck_o(sck_w[0]), .spi_mosi_o(mosi_w[0]), .spi_miso_i(miso_r[0])
    );
    spi_mem_master #(.CLK_DIV(2), .ADDR_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1),
        .spi_cs_n_o(cs_w[1]), .spi_sck_o(sck_w[1]), .spi_mosi_o(mosi_w[1]), .spi_miso_i(miso_r[1])
    );

    assign rv_w[0]   = bus0.resp_valid;
    assign rv_w[1]   = bus1.resp_valid;
    assign rdy_w[0]  = bus0.req_ready;
    assign rdy_w[1]  = bus1.req_ready;
    assign busy_w[0] = bus0.busy;
    assign busy_w[1] = bus1.busy;
    assign rd_w[0]   = bus0.resp_rdata;
    assign rd_w[1]   = bus1.resp_rdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [7:0]  rdata;
        logic [39:0] frame;
        int          nbits;
        longint      acc;
    } exp_t;
    exp_t sb0[$];
    exp_t sb1[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Serial SRAM contents seen by reads (hand-chosen bytes).
    function automatic logic [7:0] mem_rd(input logic [15:0] a);
        case (a)
            16'h1234: return 8'hA5;
            16'h0001: return 8'h96;
            16'hFFFF: return 8'h7E;
            16'h0000: return 8'h5A;
            default:  return 8'h00;
        endcase
    endfunction

    // SRAM model state per instance
    bit          cs_p [2];
    bit          sck_p [2];
    bit          mosi_p [2];
    bit          had_frame [2];
    int          bitn [2];
    int          low_cnt [2];
    int          hi_cnt [2];
    int          gap_cnt [2];
    int          dstart [2];
    int          mosi_err = 0;
    logic [39:0] frame [2];
    logic [7:0]  data [2];

    // SPI slave model: sampled away from clk edges; captures on SCK rise, drives MISO after SCK fall.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            cs_p[k]   <= cs_w[k];
            sck_p[k]  <= sck_w[k];
            mosi_p[k] <= mosi_w[k];
            if (!cs_w[k]) begin
                if (cs_p[k]) begin
                    if (had_frame[k]) begin
                        checks++;
                        if (gap_cnt[k] < 2 * (k + 1)) begin
                            fails++;
                            $display("FAIL cs_gap dut%0d actual=%0d required>=%0d", k, gap_cnt[k], 2 * (k + 1));
                        end
                    end
                    low_cnt[k] <= 1;
                    hi_cnt[k]  <= 0;
                    bitn[k]    <= 0;
                    frame[k]   <= 40'h0;
                    dstart[k]  <= 99;
                    miso_r[k]  <= 1'b1;
                end else begin
                    low_cnt[k] <= low_cnt[k] + 1;
                    if (sck_w[k]) hi_cnt[k] <= hi_cnt[k] + 1;
                    if (sck_w[k] && !sck_p[k]) begin
                        frame[k] <= {frame[k][38:0], mosi_w[k]};
                        bitn[k]  <= bitn[k] + 1;
                        if (bitn[k] == 23) begin
                            data[k]   <= mem_rd({frame[k][14:0], mosi_w[k]});
                            dstart[k] <= (frame[k][22:15] == 8'h0B) ? 32 : 24;
                        end
                    end
                    if (!sck_w[k] && sck_p[k]) begin
                        if (bitn[k] >= dstart[k] && bitn[k] < dstart[k] + 8)
                            miso_r[k] <= data[k][7 - (bitn[k] - dstart[k])];
                        else
                            miso_r[k] <= 1'b1;
                    end
                    if (sck_w[k] && sck_p[k] && (mosi_w[k] != mosi_p[k]))
                        mosi_err <= mosi_err + 1;
                end
            end else begin
                if (!cs_p[k]) begin
                    had_frame[k] <= 1'b1;
                    gap_cnt[k]   <= 1;
                end else begin
                    gap_cnt[k] <= gap_cnt[k] + 1;
                end
            end
        end
    end

    int resp_cnt [2];
    bit rv_p [2];

    task automatic compare_resp(input int k);
        exp_t e;
        int   sz;
        sz = (k == 0) ? sb0.size() : sb1.size();
        if (sz == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_resp dut%0d actual=resp_valid required=no_response", k);
            return;
        end
        if (k == 0) e = sb0.pop_front();
        else        e = sb1.pop_front();
        check($sformatf("rdata_dut%0d", k), rd_w[k], e.rdata);
        check($sformatf("mosi_frame_dut%0d", k), frame[k], e.frame);
        check($sformatf("sck_pulses_dut%0d", k), bitn[k], e.nbits);
        check($sformatf("sck_high_cycles_dut%0d", k), hi_cnt[k], e.nbits * (k + 1));
        check($sformatf("cs_low_cycles_dut%0d", k), low_cnt[k], 2 * e.nbits * (k + 1));
        check($sformatf("resp_latency_dut%0d", k), cyc - e.acc, 2 * e.nbits * (k + 1));
        check($sformatf("busy_at_resp_dut%0d", k), busy_w[k], 1'b1);
    endtask

    // Response monitor: one scoreboard pop per resp_valid pulse; a stretched pulse is an error.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            rv_p[k] <= rv_w[k];
            if (rv_w[k] === 1'b1) begin
                if (rv_p[k]) begin
                    checks++;
                    fails++;
                    $display("FAIL resp_pulse_width dut%0d actual=multi_cycle required=one_cycle", k);
                end else begin
                    resp_cnt[k] <= resp_cnt[k] + 1;
                    compare_resp(k);
                end
            end
        end
    end

    task automatic set_req(input int k, input logic v, input logic we, input logic [15:0] a, input logic [7:0] wd);
        if (k == 0) begin
            bus0.req_valid = v; bus0.req_we = we; bus0.req_addr = a; bus0.req_wdata = wd;
        end else begin
            bus1.req_valid = v; bus1.req_we = we; bus1.req_addr = a; bus1.req_wdata = wd;
        end
    endtask

    // Issue one request; expected response is queued at the accept edge.
    task automatic issue(input int k, input logic we, input logic [15:0] a, input logic [7:0] wd,
                         input logic [7:0] exp_rd, input bit push, input bit hold);
        exp_t e;
        int   n;
        @(negedge clk);
        set_req(k, 1'b1, we, a, wd);
        n = 0;
        while (!rdy_w[k]) begin
            @(negedge clk);
            n++;
            if (n > 2000) begin
                checks++; fails++;
                $display("FAIL accept_timeout dut%0d actual=no_ready required=ready", k);
                break;
            end
        end
        @(posedge clk);
        #1;
        e.acc   = cyc;
        e.rdata = exp_rd;
        if (we) begin
            e.frame = {8'h00, 8'h02, a, wd};
            e.nbits = 32;
        end else begin
`ifdef SPI_MEM_FASTREAD_EN
            e.frame = {8'h0B, a, 16'h0000};
            e.nbits = 40;
`else
            e.frame = {8'h00, 8'h03, a, 8'h00};
            e.nbits = 32;
`endif
        end
        if (push) begin
            if (k == 0) sb0.push_back(e);
            else        sb1.push_back(e);
        end
        if (!hold) set_req(k, 1'b0, ~we, 16'hDEAD, 8'hE7);
    endtask

    task automatic wait_drain(input int k);
        int n;
        n = 0;
        while (((k == 0) ? sb0.size() : sb1.size()) != 0 || !rdy_w[k]) begin
            @(negedge clk);
            n++;
            if (n > 3000) begin
                checks++; fails++;
                $display("FAIL drain_timeout dut%0d actual=pending required=idle", k);
                break;
            end
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        set_req(0, 1'b1, 1'b0, 16'h1234, 8'h00);
        set_req(1, 1'b1, 1'b1, 16'h4321, 8'h11);
        repeat (3) @(negedge clk);
        check("rst_cs_n", cs_w[0], 1'b1);
        check("rst_sck", sck_w[0], 1'b0);
        check("rst_mosi", mosi_w[0], 1'b0);
        check("rst_resp_valid", rv_w[0], 1'b0);
        check("rst_req_ready", rdy_w[0], 1'b1);
        check("rst_resp_rdata", rd_w[0], 8'h00);
        check("rst_busy", busy_w[0], 1'b0);
        check("rst_cs_n_dut1", cs_w[1], 1'b1);
        set_req(0, 1'b0, 1'b0, 16'h0000, 8'h00);
        set_req(1, 1'b0, 1'b0, 16'h0000, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // plain read, CLK_DIV=1: response in cycle 65 after accept
        issue(0, 1'b0, 16'h1234, 8'h00, 8'hA5, 1'b1, 1'b0);
        wait_drain(0);
        // write leaves resp_rdata unchanged
        issue(0, 1'b1, 16'h0100, 8'h55, 8'hA5, 1'b1, 1'b0);
        wait_drain(0);
        // write at CLK_DIV=2
        issue(1, 1'b1, 16'h00FF, 8'h3C, 8'h00, 1'b1, 1'b0);
        wait_drain(1);
        // back-to-back reads with req_valid held high
        issue(0, 1'b0, 16'hFFFF, 8'h00, 8'h7E, 1'b1, 1'b1);
        issue(0, 1'b0, 16'h0001, 8'h00, 8'h96, 1'b1, 1'b0);
        wait_drain(0);

        // reset during a frame, right after bit 10
        issue(0, 1'b0, 16'h1234, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        n = 0;
        while (bitn[0] < 10 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("abort_bit_position", bitn[0], 10);
        rst_n = 1'b0;
        #1;
        check("abort_cs_n", cs_w[0], 1'b1);
        check("abort_sck", sck_w[0], 1'b0);
        check("abort_mosi", mosi_w[0], 1'b0);
        check("abort_resp_rdata", rd_w[0], 8'h00);
        check("abort_busy", busy_w[0], 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        issue(0, 1'b0, 16'h0001, 8'h00, 8'h96, 1'b1, 1'b0);
        wait_drain(0);
`ifdef SPI_MEM_FASTREAD_EN
        // fast read: 40 SCK pulses, response in cycle 81 at CLK_DIV=1
        issue(0, 1'b0, 16'h0000, 8'h00, 8'h5A, 1'b1, 1'b0);
        wait_drain(0);
`endif
        repeat (4) @(negedge clk);
`ifdef SPI_MEM_FASTREAD_EN
        check("resp_count_dut0", resp_cnt[0], 6);
`else
        check("resp_count_dut0", resp_cnt[0], 5);
`endif
        check("resp_count_dut1", resp_cnt[1], 1);
        check("mosi_stable_while_sck_high", mosi_err, 0);
        check("final_rdata_dut1", rd_w[1], 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #1000000;
        checks++;
        fails++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
